// File: rtl/pin_entry_collector.sv
// pin_entry_collector
//   Upstream stage of the password verifier. Collects keypad key events into
//   a two-digit BCD password and issues a one-cycle enter strobe. Keys are
//   only accepted while a vehicle is present; partial entries are discarded
//   on timeout, clear key or vehicle departure.
//
// Ports
//   clk            in   system clock, rising edge
//   reset          in   synchronous reset, active-high
//   arrival_sensor in   vehicle present at gate
//   key_valid      in   key event strobe (raw press level with debounce)
//   key_code       in   0-9 digit, A clear, E enter, others ignored
//   password       out  {first digit, second digit} BCD
//   enter          out  one-cycle submit pulse
//   digit_count    out  digits currently buffered (0-2)
//   entry_timeout  out  one-cycle pulse when a partial entry times out
//
// Build option
//   KEY_DEBOUNCE_EN : key_valid is treated as a raw level and each press is
//                     accepted after DEBOUNCE_CYCLES stable cycles.
module pin_entry_collector #(
   parameter int unsigned TIMEOUT_CYCLES  = 1000,
   parameter int unsigned DEBOUNCE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       arrival_sensor,
   input  logic       key_valid,
   input  logic [3:0] key_code,
   output logic [7:0] password,
   output logic       enter,
   output logic [1:0] digit_count,
   output logic       entry_timeout
);

   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
   localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

   if (TIMEOUT_CYCLES < 2 || DEBOUNCE_CYCLES < 1) begin : g_bad_param
      $error("pin_entry_collector: TIMEOUT_CYCLES must be >= 2 and DEBOUNCE_CYCLES >= 1");
   end

   typedef enum logic [1:0] {IDLE, ENTRY, FULL, SUBMIT} state_t;

   // Key event seen by the entry FSM
   logic       key_evt;
   logic [3:0] key_cd;

`ifdef KEY_DEBOUNCE_EN
   localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE_CYCLES);

   logic [DW-1:0] hi_q, hi_d, lo_q, lo_d, hi_nxt;
   logic          armed_q, armed_d;
   logic [3:0]    code_q, code_d, evtc_q, evtc_d;
   logic          evt_q, evt_d;

   // armed: a new press may be recognised. It drops once a press is accepted
   // and returns only after key_valid has been low for DEBOUNCE_CYCLES.
   always_comb begin
      hi_d    = hi_q;
      lo_d    = lo_q;
      armed_d = armed_q;
      code_d  = code_q;
      evt_d   = 1'b0;
      evtc_d  = evtc_q;
      hi_nxt  = '0;
      if (key_valid) begin
         lo_d = '0;
         if (armed_q) begin
            // A code change restarts the stability count
            hi_nxt = (hi_q != '0 && key_code == code_q) ? hi_q + DW'(1) : DW'(1);
            code_d = key_code;
            if (hi_nxt == DMAX) begin
               evt_d   = 1'b1;
               evtc_d  = key_code;
               armed_d = 1'b0;
               hi_d    = '0;
            end else begin
               hi_d = hi_nxt;
            end
         end else begin
            hi_d = '0;
         end
      end else begin
         hi_d = '0;
         if (!armed_q) begin
            if (lo_q + DW'(1) == DMAX) begin
               armed_d = 1'b1;
               lo_d    = '0;
            end else begin
               lo_d = lo_q + DW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hi_q    <= '0;
         lo_q    <= '0;
         armed_q <= 1'b1;
         code_q  <= '0;
         evt_q   <= 1'b0;
         evtc_q  <= '0;
      end else begin
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         armed_q <= armed_d;
         code_q  <= code_d;
         evt_q   <= evt_d;
         evtc_q  <= evtc_d;
      end
   end

   assign key_evt = evt_q;
   assign key_cd  = evtc_q;
`else
   assign key_evt = key_valid;
   assign key_cd  = key_code;
`endif

   state_t        state_q, state_d;
   logic [7:0]    pw_q, pw_d;
   logic [1:0]    cnt_q, cnt_d;
   logic [TW-1:0] tcnt_q, tcnt_d;
   logic          enter_q, enter_d;
   logic          to_q, to_d;
   logic          is_digit, is_clear, is_enter, key_act;

   assign is_digit = (key_cd <= 4'h9);
   assign is_clear = (key_cd == 4'hA);
   assign is_enter = (key_cd == 4'hE);

   always_comb begin
      state_d = state_q;
      pw_d    = pw_q;
      cnt_d   = cnt_q;
      tcnt_d  = '0;
      // enter is a registered copy of the SUBMIT state, so it follows one
      // cycle behind and survives a departure during SUBMIT.
      enter_d = (state_q == SUBMIT);
      to_d    = 1'b0;
      key_act = 1'b0;
      case (state_q)
         IDLE: begin
            if (arrival_sensor) begin
               state_d = ENTRY;
               cnt_d   = 2'd0;
            end
         end
         ENTRY, FULL: begin
            if (key_evt) begin
               if (is_clear) begin
                  pw_d    = 8'h00;
                  cnt_d   = 2'd0;
                  state_d = ENTRY;
                  key_act = 1'b1;
               end else if (is_digit && state_q == ENTRY) begin
                  pw_d    = (cnt_q == 2'd0) ? {4'h0, key_cd} : {pw_q[3:0], key_cd};
                  cnt_d   = cnt_q + 2'd1;
                  state_d = (cnt_q == 2'd1) ? FULL : ENTRY;
                  key_act = 1'b1;
               end else if (is_enter && state_q == FULL) begin
                  state_d = SUBMIT;
                  key_act = 1'b1;
               end
            end
            // An accepted key takes priority over an expiring counter
            if (!key_act && cnt_q != 2'd0) begin
               if (tcnt_q == TMAX) begin
                  pw_d    = 8'h00;
                  cnt_d   = 2'd0;
                  state_d = ENTRY;
                  to_d    = 1'b1;
               end else begin
                  tcnt_d = tcnt_q + TW'(1);
               end
            end
         end
         SUBMIT: begin
            state_d = ENTRY;
            cnt_d   = 2'd0;
         end
         default: state_d = IDLE;
      endcase
      if (!arrival_sensor && state_q != IDLE) begin
         state_d = IDLE;
         cnt_d   = 2'd0;
         pw_d    = 8'h00;
         tcnt_d  = '0;
         to_d    = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         pw_q    <= 8'h00;
         cnt_q   <= 2'd0;
         tcnt_q  <= '0;
         enter_q <= 1'b0;
         to_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         pw_q    <= pw_d;
         cnt_q   <= cnt_d;
         tcnt_q  <= tcnt_d;
         enter_q <= enter_d;
         to_q    <= to_d;
      end
   end

   assign password      = pw_q;
   assign enter         = enter_q;
   assign digit_count   = cnt_q;
   assign entry_timeout = to_q;

endmodule

// File: tb/tb_pin_entry_collector.sv
module tb_pin_entry_collector;

`ifdef KEY_DEBOUNCE_EN
   localparam int unsigned TB_TO = 64;
`else
   localparam int unsigned TB_TO = 16;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       arrival_sensor = 1'b0;
   logic       key_valid = 1'b0;
   logic [3:0] key_code = 4'h0;
   logic [7:0] password;
   logic       enter;
   logic [1:0] digit_count;
   logic       entry_timeout;

   int checks = 0;
   int errors = 0;

   pin_entry_collector #(.TIMEOUT_CYCLES(TB_TO), .DEBOUNCE_CYCLES(4)) dut (
      .clk(clk),
      .reset(reset),
      .arrival_sensor(arrival_sensor),
      .key_valid(key_valid),
      .key_code(key_code),
      .password(password),
      .enter(enter),
      .digit_count(digit_count),
      .entry_timeout(entry_timeout)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       arr;
      logic       kv;
      logic [3:0] code;
      logic [7:0] pw;
      logic       en;
      logic [1:0] cnt;
      logic       to;
   } vec_t;

   vec_t vq[$];

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [7:0] pw, input logic en,
                          input logic [1:0] cnt, input logic to);
      chk({tag, "_pw"}, password, pw);
      chk({tag, "_en"}, {7'd0, enter}, {7'd0, en});
      chk({tag, "_cnt"}, {6'd0, digit_count}, {6'd0, cnt});
      chk({tag, "_to"}, {7'd0, entry_timeout}, {7'd0, to});
   endtask

   // Drive inputs for one edge, then sample 1 time unit after the edge
   task automatic step(input logic arr, input logic kv, input logic [3:0] code);
      arrival_sensor = arr;
      key_valid      = kv;
      key_code       = code;
      @(posedge clk);
      #1;
   endtask

   // Idle cycles expecting no timeout pulse
   task automatic idle_no_to(input string tag, input int n);
      for (int i = 0; i < n; i++) begin
         step(1'b1, 1'b0, 4'h0);
         chk($sformatf("%s_idle%0d_to", tag, i), {7'd0, entry_timeout}, 8'd0);
      end
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk_all("reset", 8'h00, 1'b0, 2'd0, 1'b0);
      reset = 1'b0;

`ifdef KEY_DEBOUNCE_EN
      step(1'b1, 1'b0, 4'h0);
      // Too-short press: 3 cycles
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 4'h5);
      for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 4'h0);
      chk_all("db_short", 8'h00, 1'b0, 2'd0, 1'b0);
      // Long press: 10 cycles, exactly one digit
      for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 4'h5);
      for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 4'h0);
      chk_all("db_long", 8'h05, 1'b0, 2'd1, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 4'h0);
      for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 4'h6);
      for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 4'h0);
      chk_all("db_second", 8'h56, 1'b0, 2'd2, 1'b0);
`else
      //             arr   kv    code   pw     en    cnt   to
      vq.push_back('{1'b1, 1'b0, 4'h0, 8'h00, 1'b0, 2'd0, 1'b0}); // IDLE->ENTRY
      vq.push_back('{1'b1, 1'b1, 4'h1, 8'h01, 1'b0, 2'd1, 1'b0});
      vq.push_back('{1'b1, 1'b1, 4'h2, 8'h12, 1'b0, 2'd2, 1'b0});
      vq.push_back('{1'b1, 1'b1, 4'hE, 8'h12, 1'b0, 2'd2, 1'b0}); // -> SUBMIT
      vq.push_back('{1'b1, 1'b0, 4'h0, 8'h12, 1'b1, 2'd0, 1'b0}); // pulse
      vq.push_back('{1'b1, 1'b0, 4'h0, 8'h12, 1'b0, 2'd0, 1'b0});
      vq.push_back('{1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 2'd0, 1'b0}); // -> IDLE
      vq.push_back('{1'b0, 1'b1, 4'h5, 8'h00, 1'b0, 2'd0, 1'b0});
      vq.push_back('{1'b0, 1'b1, 4'hE, 8'h00, 1'b0, 2'd0, 1'b0});
      vq.push_back('{1'b1, 1'b0, 4'h0, 8'h00, 1'b0, 2'd0, 1'b0});
      vq.push_back('{1'b1, 1'b1, 4'h7, 8'h07, 1'b0, 2'd1, 1'b0});
      vq.push_back('{1'b1, 1'b1, 4'hE, 8'h07, 1'b0, 2'd1, 1'b0}); // enter ignored
      vq.push_back('{1'b1, 1'b1, 4'h3, 8'h73, 1'b0, 2'd2, 1'b0});
      vq.push_back('{1'b1, 1'b1, 4'hE, 8'h73, 1'b0, 2'd2, 1'b0});
      vq.push_back('{1'b1, 1'b0, 4'h0, 8'h73, 1'b1, 2'd0, 1'b0});
      vq.push_back('{1'b1, 1'b0, 4'h0, 8'h73, 1'b0, 2'd0, 1'b0});
      vq.push_back('{1'b1, 1'b1, 4'h1, 8'h01, 1'b0, 2'd1, 1'b0});
      vq.push_back('{1'b1, 1'b1, 4'h2, 8'h12, 1'b0, 2'd2, 1'b0});
      vq.push_back('{1'b1, 1'b1, 4'h3, 8'h12, 1'b0, 2'd2, 1'b0}); // digit in FULL
      vq.push_back('{1'b1, 1'b1, 4'hB, 8'h12, 1'b0, 2'd2, 1'b0}); // unused code
      vq.push_back('{1'b1, 1'b1, 4'hA, 8'h00, 1'b0, 2'd0, 1'b0}); // clear
      vq.push_back('{1'b1, 1'b1, 4'h4, 8'h04, 1'b0, 2'd1, 1'b0});
      vq.push_back('{1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 2'd0, 1'b0}); // departure
      vq.push_back('{1'b0, 1'b1, 4'h4, 8'h00, 1'b0, 2'd0, 1'b0});
      vq.push_back('{1'b1, 1'b0, 4'h0, 8'h00, 1'b0, 2'd0, 1'b0});
      vq.push_back('{1'b1, 1'b1, 4'h8, 8'h08, 1'b0, 2'd1, 1'b0});
      vq.push_back('{1'b1, 1'b1, 4'h9, 8'h89, 1'b0, 2'd2, 1'b0});
      vq.push_back('{1'b1, 1'b1, 4'hE, 8'h89, 1'b0, 2'd2, 1'b0});
      vq.push_back('{1'b1, 1'b1, 4'h5, 8'h89, 1'b1, 2'd0, 1'b0}); // key in SUBMIT ignored
      vq.push_back('{1'b1, 1'b0, 4'h0, 8'h89, 1'b0, 2'd0, 1'b0});

      foreach (vq[i]) begin
         step(vq[i].arr, vq[i].kv, vq[i].code);
         chk_all($sformatf("vec%0d", i), vq[i].pw, vq[i].en, vq[i].cnt, vq[i].to);
      end

      // Timeout from ENTRY after 16 idle cycles
      step(1'b1, 1'b1, 4'h9);
      chk_all("to_key", 8'h09, 1'b0, 2'd1, 1'b0);
      idle_no_to("to_a", 15);
      step(1'b1, 1'b0, 4'h0);
      chk_all("to_fire", 8'h00, 1'b0, 2'd0, 1'b1);
      step(1'b1, 1'b0, 4'h0);
      chk_all("to_after", 8'h00, 1'b0, 2'd0, 1'b0);

      // Key at cycle 15 prevents timeout; then FULL times out
      step(1'b1, 1'b1, 4'h9);
      idle_no_to("pv_a", 14);
      step(1'b1, 1'b1, 4'h4);
      chk_all("pv_key", 8'h94, 1'b0, 2'd2, 1'b0);
      idle_no_to("pv_b", 15);
      step(1'b1, 1'b0, 4'h0);
      chk_all("full_to", 8'h00, 1'b0, 2'd0, 1'b1);

      // Key on the expiry edge wins
      step(1'b1, 1'b1, 4'h9);
      idle_no_to("sim", 15);
      step(1'b1, 1'b1, 4'h4);
      chk_all("sim_key", 8'h94, 1'b0, 2'd2, 1'b0);
      step(1'b1, 1'b1, 4'hA);
      chk_all("sim_clr", 8'h00, 1'b0, 2'd0, 1'b0);

      // Departure during SUBMIT: pulse still completes
      step(1'b1, 1'b1, 4'h1);
      step(1'b1, 1'b1, 4'h2);
      step(1'b1, 1'b1, 4'hE);
      step(1'b0, 1'b0, 4'h0);
      chk_all("dep_sub", 8'h00, 1'b1, 2'd0, 1'b0);
      step(1'b0, 1'b0, 4'h0);
      chk_all("dep_sub2", 8'h00, 1'b0, 2'd0, 1'b0);

      // Reset in SUBMIT forces enter low
      step(1'b1, 1'b0, 4'h0);
      step(1'b1, 1'b1, 4'h3);
      step(1'b1, 1'b1, 4'h4);
      chk_all("rs_pre", 8'h34, 1'b0, 2'd2, 1'b0);
      step(1'b1, 1'b1, 4'hE);
      reset = 1'b1;
      step(1'b1, 1'b0, 4'h0);
      chk_all("rs_sub", 8'h00, 1'b0, 2'd0, 1'b0);
      reset = 1'b0;
      step(1'b1, 1'b0, 4'h0);
      chk_all("rs_post", 8'h00, 1'b0, 2'd0, 1'b0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
